// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared EtherType constants and init-handshake state encoding
package eth_rx_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

  // Entry 0 is ARP and entry 1 is IPv4 so the handshake indices default to 0/1
  localparam logic [63:0] ETH_DEFAULT_TYPE_LIST =
    {ETH_TYPE_VLAN, ETH_TYPE_IPV6, ETH_TYPE_IPV4, ETH_TYPE_ARP};

  typedef enum logic [1:0] {
    ST_WAIT_ARP = 2'd0,
    ST_WAIT_IP  = 2'd1,
    ST_DONE     = 2'd2
  } init_state_e;

endpackage

// File: rtl/eth_evt_stretch.sv
// rtl/eth_evt_stretch.sv - reloadable down-counter that stretches a one-cycle event
module eth_evt_stretch #(
  parameter int STRETCH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  output logic o_pulse
);

  localparam int CW = $clog2(STRETCH + 1);

  logic [CW-1:0] r_cnt;

  // Load (or reload while still counting) to STRETCH, then count down to idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(STRETCH);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/eth_rx_event_monitor.sv
// rtl/eth_rx_event_monitor.sv - EtherType event classifier, counters and TCP/IP init handshake
module eth_rx_event_monitor
  import eth_rx_pkg::*;
#(
  parameter int                     N_TYPES   = 4,
  parameter logic [N_TYPES*16-1:0]  TYPE_LIST = ETH_DEFAULT_TYPE_LIST,
  parameter int                     CNT_W     = 16,
  parameter int                     STRETCH   = 4,
  parameter int                     ARP_IDX   = 0,
  parameter int                     IP_IDX    = 1,
  parameter int                     TIMEOUT   = 1048576
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_pkt_end,
  input  logic [15:0]               i_pkt_type,
  input  logic                      i_pkt_err,
  input  logic                      i_clr_cnt,
  input  logic                      i_init_restart,
  output logic [N_TYPES-1:0]        o_evt_pulse,
  output logic [N_TYPES*CNT_W-1:0]  o_evt_cnt,
  output logic [CNT_W-1:0]          o_unknown_cnt,
  output logic [CNT_W-1:0]          o_err_cnt,
  output logic                      o_tcpip_init_done,
  output logic                      o_init_done_pulse,
  output logic                      o_init_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_TYPES-1:0] w_match;
  logic               r_s1_valid;
  logic               r_s1_err;
  logic [N_TYPES-1:0] r_s1_match;
  logic               w_good;
  logic [N_TYPES-1:0] w_evt;
  logic               w_unknown;
  logic               w_arp;
  logic               w_ip;
  logic [CNT_W-1:0]   r_evt_cnt [N_TYPES];
  logic [CNT_W-1:0]   r_unknown_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  init_state_e        r_state;
  init_state_e        w_next_state;
  logic [TW-1:0]      r_timer;
  logic               w_timer_exp;
  logic               w_done_d;
  logic               w_done_pulse_d;
  logic               w_timeout_d;
  logic               r_done;
  logic               r_done_pulse;
  logic               r_timeout;

  // One-hot EtherType match; the lowest index wins when the list has duplicates
  always_comb begin
    logic v_found;
    v_found = 1'b0;
    w_match = '0;
    for (int i = 0; i < N_TYPES; i++) begin
      if (!v_found && (i_pkt_type == TYPE_LIST[16*i +: 16])) begin
        w_match[i] = 1'b1;
        v_found    = 1'b1;
      end
    end
  end

  // Stage 1: capture frame-end strobe, error flag and match vector
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_match <= '0;
    end else begin
      r_s1_valid <= i_pkt_end;
      r_s1_err   <= i_pkt_end & i_pkt_err;
      r_s1_match <= i_pkt_end ? w_match : '0;
    end
  end

  // Errored frames only feed err_cnt; everything else needs a clean frame
  assign w_good    = r_s1_valid & ~r_s1_err;
  assign w_evt     = r_s1_match & {N_TYPES{w_good}};
  assign w_unknown = w_good & ~(|r_s1_match);
  assign w_arp     = w_evt[ARP_IDX];
  assign w_ip      = w_evt[IP_IDX];

  genvar g;
  generate
    for (g = 0; g < N_TYPES; g++) begin : g_type
      // Stage 2: per-type saturating counter, clear has priority over increment
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_evt_cnt[g] <= '0;
        end else if (i_clr_cnt) begin
          r_evt_cnt[g] <= '0;
        end else if (w_evt[g] && (r_evt_cnt[g] != CNT_MAX)) begin
          r_evt_cnt[g] <= r_evt_cnt[g] + 1'b1;
        end
      end

      assign o_evt_cnt[CNT_W*g +: CNT_W] = r_evt_cnt[g];

      eth_evt_stretch #(
        .STRETCH (STRETCH)
      ) u_stretch (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_evt[g]),
        .o_pulse (o_evt_pulse[g])
      );
    end
  endgenerate

  // Stage 2: unknown-type and error counters, saturating, clear has priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_unknown_cnt <= '0;
      r_err_cnt     <= '0;
    end else if (i_clr_cnt) begin
      r_unknown_cnt <= '0;
      r_err_cnt     <= '0;
    end else begin
      if (w_unknown && (r_unknown_cnt != CNT_MAX)) r_unknown_cnt <= r_unknown_cnt + 1'b1;
      if (r_s1_err && (r_err_cnt != CNT_MAX))      r_err_cnt     <= r_err_cnt + 1'b1;
    end
  end

  assign w_timer_exp = (r_timer == TW'(TIMEOUT - 1));

  // Handshake state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_WAIT_ARP;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake next state: restart first, IPv4 beats timeout, a fresh ARP postpones timeout
  always_comb begin
    w_next_state = r_state;
    if (i_init_restart) begin
      w_next_state = ST_WAIT_ARP;
    end else begin
      case (r_state)
        ST_WAIT_ARP: if (w_arp) w_next_state = ST_WAIT_IP;
        ST_WAIT_IP: begin
          if (w_ip)                        w_next_state = ST_DONE;
          else if (!w_arp && w_timer_exp)  w_next_state = ST_WAIT_ARP;
        end
        ST_DONE:     w_next_state = ST_DONE;
        default:     w_next_state = ST_WAIT_ARP;
      endcase
    end
  end

  // Handshake outputs decoded from the transition about to be taken
  always_comb begin
    w_done_d       = (w_next_state == ST_DONE);
    w_done_pulse_d = (r_state == ST_WAIT_IP) && (w_next_state == ST_DONE);
    w_timeout_d    = (r_state == ST_WAIT_IP) && (w_next_state == ST_WAIT_ARP) && !i_init_restart;
  end

  // Register handshake outputs so they line up with the state they describe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done       <= w_done_d;
      r_done_pulse <= w_done_pulse_d;
      r_timeout    <= w_timeout_d;
    end
  end

  // Timer counts only while staying in WAIT_IP; entry, ARP reload and exits zero it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if ((r_state == ST_WAIT_IP) && (w_next_state == ST_WAIT_IP) && !w_arp) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  assign o_unknown_cnt     = r_unknown_cnt;
  assign o_err_cnt         = r_err_cnt;
  assign o_tcpip_init_done = r_done;
  assign o_init_done_pulse = r_done_pulse;
  assign o_init_timeout    = r_timeout;

endmodule

// File: tb/tb_eth_rx_event_monitor.sv
// tb/tb_eth_rx_event_monitor.sv - randomized and directed bench for eth_rx_event_monitor
module tb_eth_rx_event_monitor;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int ST  = 4;
  localparam int TO  = 64;
  localparam int MAXC = 15;

  localparam logic [15:0] T_ARP  = 16'h0806;
  localparam logic [15:0] T_IPV4 = 16'h0800;
  localparam logic [15:0] T_IPV6 = 16'h86DD;
  localparam logic [15:0] T_VLAN = 16'h8100;
  localparam logic [15:0] T_LLDP = 16'h88CC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pkt_end, pkt_err, clr_cnt, init_restart;
  logic [15:0]   pkt_type;
  logic [N-1:0]  evt_pulse;
  logic [N*CW-1:0] evt_cnt;
  logic [CW-1:0] unknown_cnt, err_cnt;
  logic          init_done, done_pulse, init_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int      m_cnt [N];
  int      m_unk, m_err;
  longint  m_last [N];
  int      m_state;      // 0 wait ARP, 1 wait IP, 2 done
  longint  m_deadline;
  longint  edge_no = 0;
  bit      p_v, p_err;
  logic [15:0] p_type;

  // expected outputs after the most recent edge
  logic [N-1:0]    e_pulse;
  logic [N*CW-1:0] e_cnt;
  logic [CW-1:0]   e_unk, e_err;
  logic            e_done, e_dp, e_to;

  always #5 clk = ~clk;

  eth_rx_event_monitor #(
    .N_TYPES (N),
    .TYPE_LIST ({T_VLAN, T_IPV6, T_IPV4, T_ARP}),
    .CNT_W   (CW),
    .STRETCH (ST),
    .ARP_IDX (0),
    .IP_IDX  (1),
    .TIMEOUT (TO)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pkt_end         (pkt_end),
    .i_pkt_type        (pkt_type),
    .i_pkt_err         (pkt_err),
    .i_clr_cnt         (clr_cnt),
    .i_init_restart    (init_restart),
    .o_evt_pulse       (evt_pulse),
    .o_evt_cnt         (evt_cnt),
    .o_unknown_cnt     (unknown_cnt),
    .o_err_cnt         (err_cnt),
    .o_tcpip_init_done (init_done),
    .o_init_done_pulse (done_pulse),
    .o_init_timeout    (init_timeout)
  );

  function automatic int idx_of(input logic [15:0] t);
    case (t)
      T_ARP:   return 0;
      T_IPV4:  return 1;
      T_IPV6:  return 2;
      T_VLAN:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_outputs();
    for (int i = 0; i < N; i++) begin
      e_pulse[i] = ((edge_no - m_last[i]) < ST);
      e_cnt[CW*i +: CW] = CW'(m_cnt[i]);
    end
    e_unk  = CW'(m_unk);
    e_err  = CW'(m_err);
    e_done = (m_state == 2);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_last[i] = -1000000;
    end
    m_unk = 0; m_err = 0; m_state = 0; m_deadline = 0;
    p_v = 0; p_err = 0; p_type = '0;
    e_dp = 0; e_to = 0;
    model_outputs();
  endtask

  // apply the frame captured one edge ago plus this edge's clear/restart
  task automatic model_edge(input bit clr, input bit rs);
    int  idx;
    bit  good, arp, ip;
    e_dp = 0; e_to = 0;
    idx  = p_v ? idx_of(p_type) : -1;
    good = p_v && !p_err;
    if (clr) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_unk = 0; m_err = 0;
    end else if (p_v) begin
      if (p_err)         m_err = sat_inc(m_err);
      else if (idx >= 0) m_cnt[idx] = sat_inc(m_cnt[idx]);
      else               m_unk = sat_inc(m_unk);
    end
    if (good && idx >= 0) m_last[idx] = edge_no;
    arp = good && (idx == 0);
    ip  = good && (idx == 1);
    if (rs) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (arp) begin m_state = 1; m_deadline = edge_no + TO; end
    end else if (m_state == 1) begin
      if (ip)                           begin m_state = 2; e_dp = 1; end
      else if (arp)                     m_deadline = edge_no + TO;
      else if (edge_no == m_deadline)   begin m_state = 0; e_to = 1; end
    end
    model_outputs();
  endtask

  task automatic step(input bit pe, input logic [15:0] ty, input bit er, input bit clr, input bit rs);
    pkt_end = pe; pkt_type = ty; pkt_err = er; clr_cnt = clr; init_restart = rs;
    @(posedge clk);
    #1;
    edge_no++;
    model_edge(clr, rs);
    p_v = pe; p_type = ty; p_err = er;
    pkt_end = 0; pkt_err = 0; clr_cnt = 0; init_restart = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 16'h0000, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 0; pkt_end = 0; pkt_type = '0; pkt_err = 0; clr_cnt = 0; init_restart = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if ({evt_pulse, evt_cnt, unknown_cnt, err_cnt, init_done, done_pulse, init_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pulse=%h cnt=%h unk=%h err=%h done=%b dp=%b to=%b expected all zero",
               evt_pulse, evt_cnt, unknown_cnt, err_cnt, init_done, done_pulse, init_timeout);
    end
    rst_n = 1;
  endtask

  task automatic test_arp_pulse();
    step(1, T_ARP, 0, 0, 0);
    n_cmp++;
    if (evt_pulse !== 4'b0000) begin
      n_fail++; $display("FAIL arp_pulse_latency: got %b expected 0000", evt_pulse);
    end
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      n_cmp++;
      if (evt_pulse !== e_pulse || evt_pulse[0] !== (k <= ST)) begin
        n_fail++; $display("FAIL arp_pulse_edge%0d: got %b expected %b", k, evt_pulse, e_pulse);
      end
    end
    n_cmp++;
    if (evt_cnt[CW-1:0] !== 4'd1 || evt_cnt !== e_cnt) begin
      n_fail++; $display("FAIL arp_count: got %h expected %h", evt_cnt, e_cnt);
    end
  endtask

  task automatic test_init_done();
    idle(10);
    step(1, T_IPV4, 0, 0, 0);
    idle(1);
    n_cmp++;
    if (done_pulse !== 1'b1 || init_done !== 1'b1 || done_pulse !== e_dp) begin
      n_fail++; $display("FAIL init_done_entry: got dp=%b done=%b expected dp=1 done=1", done_pulse, init_done);
    end
    for (int k = 0; k < 6; k++) begin
      step((k % 2) == 0, T_IPV4, 0, 0, 0);
      n_cmp++;
      if (done_pulse !== 1'b0 || init_done !== 1'b1 || evt_cnt !== e_cnt) begin
        n_fail++; $display("FAIL init_done_held: got dp=%b done=%b cnt=%h expected dp=0 done=1 cnt=%h",
                           done_pulse, init_done, evt_cnt, e_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int seen;
    seen = -1;
    step(0, 16'h0000, 0, 0, 1);
    step(1, T_ARP, 0, 0, 0);
    idle(1);
    for (int k = 1; k <= 80 && seen < 0; k++) begin
      idle(1);
      n_cmp++;
      if (init_timeout !== e_to) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got %b expected %b", k, init_timeout, e_to);
      end
      if (init_timeout === 1'b1) seen = k;
    end
    n_cmp++;
    if (seen != TO || init_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_position: got cycle %0d done=%b expected cycle %0d done=0", seen, init_done, TO);
    end
    idle(1);
    n_cmp++;
    if (init_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_one_cycle: got %b expected 0", init_timeout);
    end
  endtask

  task automatic test_unknown_err();
    step(0, 16'h0000, 0, 1, 0);
    step(1, T_LLDP, 0, 0, 0);
    idle(1);
    n_cmp++;
    if (unknown_cnt !== 4'd1 || evt_pulse !== 4'b0000) begin
      n_fail++; $display("FAIL unknown_count: got unk=%h pulse=%b expected unk=1 pulse=0000", unknown_cnt, evt_pulse);
    end
    step(1, T_IPV4, 1, 0, 0);
    idle(1);
    n_cmp++;
    if (err_cnt !== 4'd1 || evt_cnt[2*CW-1:CW] !== 4'd0 || evt_pulse !== 4'b0000 || unknown_cnt !== 4'd1) begin
      n_fail++; $display("FAIL err_frame: got err=%h cnt1=%h pulse=%b unk=%h expected err=1 cnt1=0 pulse=0000 unk=1",
                         err_cnt, evt_cnt[2*CW-1:CW], evt_pulse, unknown_cnt);
    end
  endtask

  task automatic test_saturate();
    step(0, 16'h0000, 0, 1, 0);
    for (int k = 0; k < 17; k++) step(1, T_ARP, 0, 0, 0);
    idle(1);
    n_cmp++;
    if (evt_cnt[CW-1:0] !== 4'd15 || evt_cnt !== e_cnt) begin
      n_fail++; $display("FAIL saturate: got %h expected cnt0=f (%h)", evt_cnt, e_cnt);
    end
    step(1, T_ARP, 0, 0, 0);
    step(0, 16'h0000, 0, 1, 0);
    n_cmp++;
    if (evt_cnt[CW-1:0] !== 4'd0 || evt_pulse[0] !== 1'b1) begin
      n_fail++; $display("FAIL clear_beats_inc: got cnt0=%h pulse0=%b expected cnt0=0 pulse0=1",
                         evt_cnt[CW-1:0], evt_pulse[0]);
    end
  endtask

  task automatic test_restart();
    int seen;
    seen = -1;
    step(0, 16'h0000, 0, 0, 1);
    step(1, T_ARP, 0, 0, 0);
    idle(1);
    step(1, T_IPV4, 0, 0, 0);
    idle(1);
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL restart_setup_done: got %b expected 1", init_done);
    end
    step(1, T_ARP, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 1);
    n_cmp++;
    if (init_done !== 1'b0 || done_pulse !== 1'b0 || init_done !== e_done) begin
      n_fail++; $display("FAIL restart_beats_arp: got done=%b dp=%b expected done=0 dp=0", init_done, done_pulse);
    end
    idle(1);
    step(1, T_ARP, 0, 0, 0);
    idle(1);
    for (int k = 1; k <= 80 && seen < 0; k++) begin
      idle(1);
      if (init_timeout === 1'b1) seen = k;
    end
    n_cmp++;
    if (seen != TO) begin
      n_fail++; $display("FAIL restart_rearm_wait_ip: got timeout at %0d expected %0d", seen, TO);
    end
  endtask

  task automatic test_reset_midframe();
    step(1, T_ARP, 0, 0, 0);
    #2 rst_n = 0;
    #2 rst_n = 1;
    model_reset();
    idle(1);
    n_cmp++;
    if (evt_pulse !== 4'b0000 || evt_cnt !== '0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_midframe: got pulse=%b cnt=%h done=%b expected all zero", evt_pulse, evt_cnt, init_done);
    end
  endtask

  task automatic test_random();
    logic [15:0] ty;
    int          sel;
    for (int c = 0; c < 3000; c++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: ty = T_ARP;
        1: ty = T_IPV4;
        2: ty = T_IPV6;
        3: ty = T_VLAN;
        4: ty = T_LLDP;
        default: ty = 16'($urandom);
      endcase
      step($urandom_range(0, 1) == 1, ty, $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
      n_cmp++;
      if (evt_pulse !== e_pulse || evt_cnt !== e_cnt || unknown_cnt !== e_unk || err_cnt !== e_err ||
          init_done !== e_done || done_pulse !== e_dp || init_timeout !== e_to) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got pulse=%b cnt=%h unk=%h err=%h done=%b dp=%b to=%b expected pulse=%b cnt=%h unk=%h err=%h done=%b dp=%b to=%b",
                 c, evt_pulse, evt_cnt, unknown_cnt, err_cnt, init_done, done_pulse, init_timeout,
                 e_pulse, e_cnt, e_unk, e_err, e_done, e_dp, e_to);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arp_pulse();
    test_init_done();
    test_timeout();
    test_unknown_err();
    test_saturate();
    test_restart();
    test_reset_midframe();
    step(0, 16'h0000, 0, 0, 1);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
